// File: rtl/pdp11_ram_pkg.sv
// PDP-11 main-memory controller: shared types and helpers.
// Optional parity storage is enabled by defining RAM_PARITY_EN.
package pdp11_ram_pkg;

  localparam int LANE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACC  = 2'd2,
    S_ACK  = 2'd3
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pdp11_ram_lane.sv
// One byte lane of the PDP-11 RAM: DEPTH x 8 storage.
// RAM_PARITY_EN adds a stored even-parity bit and a read-side check.
module pdp11_ram_lane
  import pdp11_ram_pkg::*;
#(
  parameter int DEPTH = 32768,
  parameter int IW    = 15
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          perr
);

`ifdef RAM_PARITY_EN
  logic [LANE_W:0] mem_q [DEPTH];

  // Store the byte with its even-parity bit; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= {^din, din};
  end

  assign dout = mem_q[idx][LANE_W-1:0];
  assign perr = ^mem_q[idx];
`else
  logic [LANE_W-1:0] mem_q [DEPTH];

  // Plain byte storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= din;
  end

  assign dout = mem_q[idx];
  assign perr = 1'b0;
`endif

endmodule

// File: rtl/pdp11_ram_ctl.sv
// PDP-11 main memory: req/ack handshake, wait states, byte lanes, nxm.
// Define RAM_PARITY_EN to store and check per-lane parity.
module pdp11_ram_ctl
  import pdp11_ram_pkg::*;
#(
  parameter int DW          = 16,
  parameter int AW          = 16,
  parameter int DEPTH       = 32768,
  parameter int WAIT_STATES = 0,
  parameter     INIT_FILE   = ""
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req,
  input  logic          we,
  input  logic          byte_op,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic          nxm,
  output logic          parity_err
);

  localparam int NL  = DW / LANE_W;
  localparam int LB  = clog2(NL);
  localparam int WIW = AW - LB;
  localparam int LIW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam logic [WIW:0] DEPTH_W = (WIW + 1)'(DEPTH);

  state_e        state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic          we_q, we_d;
  logic          byte_q, byte_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          nxm_q, nxm_d;
  logic          perr_q, perr_d;

  logic [WIW-1:0] widx;
  logic [LB-1:0]  sel;
  logic [LIW-1:0] lidx;
  logic           nxm_c;
  logic           wr_en;
  logic [NL-1:0]  lane_we;
  logic [7:0]     lane_di [NL];
  logic [7:0]     lane_do [NL];
  logic [NL-1:0]  lane_pe;
  logic [DW-1:0]  rd_c;
  logic           perr_c;

  assign widx  = addr_q[AW-1:LB];
  assign sel   = addr_q[LB-1:0];
  assign lidx  = widx[LIW-1:0];
  assign nxm_c = {1'b0, widx} >= DEPTH_W;
  assign wr_en = (state_q == S_ACC) && we_q && !nxm_c;

  for (genvar i = 0; i < NL; i++) begin : g_lane
    assign lane_we[i] = wr_en && (!byte_q || sel == LB'(i));
    assign lane_di[i] = byte_q ? wdata_q[7:0]
                               : wdata_q[i*8 +: 8];
    pdp11_ram_lane #(
      .DEPTH (DEPTH),
      .IW    (LIW)
    ) u_lane (
      .clk  (clk),
      .we   (lane_we[i]),
      .idx  (lidx),
      .din  (lane_di[i]),
      .dout (lane_do[i]),
      .perr (lane_pe[i])
    );
  end

  // Steer lanes onto the read bus; byte reads land in bits 7:0.
  always_comb begin
    rd_c   = '0;
    perr_c = 1'b0;
    for (int i = 0; i < NL; i++) begin
      if (byte_q) begin
        if (sel == LB'(i)) begin
          rd_c[7:0] = lane_do[i];
          perr_c    = lane_pe[i];
        end
      end else begin
        rd_c[i*8 +: 8] = lane_do[i];
        perr_c         = perr_c | lane_pe[i];
      end
    end
  end

  // Handshake FSM, wait counter, request latches and result capture.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    we_d    = we_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    nxm_d   = nxm_q;
    perr_d  = perr_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          byte_d  = byte_op;
          addr_d  = addr;
          wdata_d = wdata;
          wcnt_d  = 4'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACC;
        end
      end
      S_WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) state_d = S_ACC;
      end
      S_ACC: begin
        nxm_d  = nxm_c;
        perr_d = !we_q && !nxm_c && perr_c;
        if (!we_q) rdata_d = nxm_c ? '0 : rd_c;
        state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; the memory array itself is not reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      nxm_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      nxm_q   <= nxm_d;
      perr_q  <= perr_d;
    end
  end

  assign busy       = state_q != S_IDLE;
  assign ack        = state_q == S_ACK;
  assign rdata      = rdata_q;
  assign nxm        = ack && nxm_q;
  assign parity_err = ack && perr_q;

endmodule

// File: tb/tb_pdp11_ram_ctl.sv
// Scoreboard bench for pdp11_ram_ctl: two instances
// (no wait states / full depth, and 3 wait states / 1K words).
module tb_pdp11_ram_ctl;

  logic        clk;
  logic        rst0, rst1;
  logic        req0, we0, bo0;
  logic        req1, we1, bo1;
  logic [15:0] addr0, wd0, addr1, wd1;
  logic        busy0, ack0, nxm0, pe0;
  logic        busy1, ack1, nxm1, pe1;
  logic [15:0] rd0, rd1;

  typedef struct {
    logic        chk;
    logic [15:0] rd;
    logic        nxm;
    logic        pe;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks;
  int   failures;

  pdp11_ram_ctl #(
    .DW(16), .AW(16), .DEPTH(32768), .WAIT_STATES(0), .INIT_FILE("")
  ) u0 (
    .clk(clk), .reset_n(rst0), .req(req0), .we(we0), .byte_op(bo0),
    .addr(addr0), .wdata(wd0), .busy(busy0), .ack(ack0),
    .rdata(rd0), .nxm(nxm0), .parity_err(pe0)
  );

  pdp11_ram_ctl #(
    .DW(16), .AW(16), .DEPTH(1024), .WAIT_STATES(3), .INIT_FILE("")
  ) u1 (
    .clk(clk), .reset_n(rst1), .req(req1), .we(we1), .byte_op(bo1),
    .addr(addr1), .wdata(wd1), .busy(busy1), .ack(ack1),
    .rdata(rd1), .nxm(nxm1), .parity_err(pe1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: pop an expectation for every ack.
  always @(negedge clk) begin
    exp_t e;
    if (ack0) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL u0_unexpected_ack actual=1 required=0");
      end else begin
        e = q0.pop_front();
        if (e.chk) chk("u0_rdata", 32'(rd0), 32'(e.rd));
        chk("u0_nxm", 32'(nxm0), 32'(e.nxm));
        chk("u0_perr", 32'(pe0), 32'(e.pe));
      end
    end
    if (ack1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL u1_unexpected_ack actual=1 required=0");
      end else begin
        e = q1.pop_front();
        if (e.chk) chk("u1_rdata", 32'(rd1), 32'(e.rd));
        chk("u1_nxm", 32'(nxm1), 32'(e.nxm));
        chk("u1_perr", 32'(pe1), 32'(e.pe));
      end
    end
  end

  // One access on instance u; checks latency from acceptance to ack.
  task automatic acc(input int u, input logic w, input logic b,
                     input logic [15:0] a, input logic [15:0] d,
                     input logic c, input logic [15:0] er,
                     input logic en, input logic ep, input int lat);
    exp_t e;
    int   n;
    e.chk = c; e.rd = er; e.nxm = en; e.pe = ep;
    @(negedge clk);
    if (u == 0) begin
      req0 = 1'b1; we0 = w; bo0 = b; addr0 = a; wd0 = d;
      q0.push_back(e);
    end else begin
      req1 = 1'b1; we1 = w; bo1 = b; addr1 = a; wd1 = d;
      q1.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    n = 1;
    while (!(u == 0 ? ack0 : ack1) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d_latency", u), 32'(n), 32'(lat));
  endtask

  initial begin
    logic bv [1:7];
    logic av [1:7];
    int   n;
    int   nb;
    int   acks;
    checks = 0; failures = 0;
    rst0 = 1'b0; rst1 = 1'b0;
    req0 = 1'b0; we0 = 1'b0; bo0 = 1'b0; addr0 = '0; wd0 = '0;
    req1 = 1'b0; we1 = 1'b0; bo1 = 1'b0; addr1 = '0; wd1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_u0_outs", {busy0, ack0, nxm0, pe0, rd0},
        {4'b0000, 16'h0000});
    chk("rst_u1_outs", {busy1, ack1, nxm1, pe1, rd1},
        {4'b0000, 16'h0000});
    rst0 = 1'b1; rst1 = 1'b1;

    // Word write/read, then byte lanes on the zero-wait instance.
    acc(0, 1, 0, 16'o500, 16'o012706, 0, 16'h0, 0, 0, 2);
    acc(0, 0, 0, 16'o500, 16'h0, 1, 16'h15C6, 0, 0, 2);
    acc(0, 1, 1, 16'o501, 16'h77AB, 0, 16'h0, 0, 0, 2);
    acc(0, 0, 0, 16'o500, 16'h0, 1, 16'hABC6, 0, 0, 2);
    acc(0, 0, 1, 16'o501, 16'h0, 1, 16'h00AB, 0, 0, 2);
    acc(0, 0, 1, 16'o500, 16'h0, 1, 16'h00C6, 0, 0, 2);
    acc(0, 0, 0, 16'o501, 16'h0, 1, 16'hABC6, 0, 0, 2);
    acc(0, 1, 1, 16'o500, 16'h993C, 0, 16'h0, 0, 0, 2);
    acc(0, 0, 0, 16'o500, 16'h0, 1, 16'hAB3C, 0, 0, 2);
    acc(0, 1, 0, 16'o503, 16'h4321, 0, 16'h0, 0, 0, 2);
    acc(0, 0, 0, 16'o502, 16'h0, 1, 16'h4321, 0, 0, 2);

`ifdef RAM_PARITY_EN
    acc(0, 1, 0, 16'o600, 16'h0F0F, 0, 16'h0, 0, 0, 2);
    u0.g_lane[0].u_lane.mem_q[192] =
      u0.g_lane[0].u_lane.mem_q[192] ^ 9'h001;
    acc(0, 0, 0, 16'o600, 16'h0, 1, 16'h0F0E, 0, 1, 2);
    acc(0, 0, 1, 16'o601, 16'h0, 1, 16'h000F, 0, 0, 2);
    acc(0, 0, 0, 16'o500, 16'h0, 1, 16'hAB3C, 0, 0, 2);
`endif

    // Wait-state instance: word 0, then nxm region.
    acc(1, 1, 0, 16'o0, 16'h1234, 0, 16'h0, 0, 0, 5);
    acc(1, 1, 0, 16'o4000, 16'hFFFF, 0, 16'h0, 1, 0, 5);
    acc(1, 0, 0, 16'o4000, 16'h0, 1, 16'h0000, 1, 0, 5);
    acc(1, 0, 0, 16'o0, 16'h0, 1, 16'h1234, 0, 0, 5);

    // req held high: second access only after the ack cycle.
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; bo1 = 1'b0; addr1 = 16'o0;
    q1.push_back('{1'b1, 16'h1234, 1'b0, 1'b0});
    q1.push_back('{1'b1, 16'h1234, 1'b0, 1'b0});
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      bv[k] = busy1;
      av[k] = ack1;
    end
    req1 = 1'b0;
    nb = 0;
    for (int k = 1; k <= 5; k++) nb += int'(bv[k]);
    chk("held_busy_cycles", 32'(nb), 32'd5);
    chk("held_ack_pattern", {27'b0, av[1], av[2], av[3], av[4], av[5]},
        32'b00001);
    chk("held_idle_gap", {30'b0, bv[6], bv[7]}, 32'b01);
    n = 7;
    while (!ack1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("held_second_ack", 32'(n), 32'd11);

    // Reset during WAIT: the pending write must not commit.
    acc(1, 1, 0, 16'd10, 16'h5555, 0, 16'h0, 0, 0, 5);
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; bo1 = 1'b0; addr1 = 16'd10; wd1 = 16'hDEAD;
    @(posedge clk);
    @(negedge clk);
    req1 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);
    chk("wait_rst_outs", {busy1, ack1, nxm1, pe1, rd1},
        {4'b0000, 16'h0000});
    rst1 = 1'b1;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      acks += int'(ack1);
    end
    chk("wait_rst_no_ack", 32'(acks), 32'd0);
    acc(1, 0, 0, 16'd10, 16'h0, 1, 16'h5555, 0, 0, 5);
    acc(1, 0, 0, 16'o0, 16'h0, 1, 16'h1234, 0, 0, 5);

    repeat (2) @(negedge clk);
    chk("u0_queue_empty", 32'(q0.size()), 32'd0);
    chk("u1_queue_empty", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
